// File: rtl/sdram_sched_pkg.sv
// Shared types and default constants for the SDRAM frame scheduler and the
// controller wrapper that consumes its command stream.
package sdram_sched_pkg;

  // Command encoding on the controller interface; the scheduler state uses the same values.
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } sched_cmd_t;

  localparam int unsigned DEFAULT_ADDR_WIDTH      = 22;
  localparam int unsigned DEFAULT_BURST_LENGTH    = 8;
  localparam int unsigned DEFAULT_FRAME_WORDS     = 153600;  // 640*480 RAW8 packed into 16-bit words
  localparam int unsigned DEFAULT_BUFFER_STRIDE   = 262144;
  localparam int unsigned DEFAULT_USED_WIDTH      = 5;
  localparam int unsigned DEFAULT_MAX_CONSECUTIVE = 4;

endpackage

// File: rtl/stream_address_gen.sv
// Per-stream frame address generator: word offset within the frame, buffer
// index, end-of-frame wrap detection and realignment to a new frame start.
module stream_address_gen
  import sdram_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int unsigned BURST_LENGTH  = DEFAULT_BURST_LENGTH,
  parameter int unsigned FRAME_WORDS   = DEFAULT_FRAME_WORDS,
  parameter int unsigned BUFFER_STRIDE = DEFAULT_BUFFER_STRIDE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  advance,      // a burst of this stream completed
  input  logic                  realign,      // restart at offset 0
  input  logic                  buffer_load,  // replace the buffer index
  input  logic                  buffer_next,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  buffer,
  output logic                  wrap          // this burst completion ends the frame
);

  localparam logic [ADDR_WIDTH-1:0] STEP        = ADDR_WIDTH'(BURST_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_OFFSET = ADDR_WIDTH'(FRAME_WORDS - BURST_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE      = ADDR_WIDTH'(BUFFER_STRIDE);

  logic [ADDR_WIDTH-1:0] offset;

  assign wrap    = advance && (offset == LAST_OFFSET);
  assign address = buffer ? (STRIDE + offset) : offset;

  // Offset advances per burst and returns to 0 at frame end or on realignment.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      offset <= '0;
      buffer <= 1'b0;
    end else begin
      if (realign || wrap) begin
        offset <= '0;
      end else if (advance) begin
        offset <= offset + STEP;
      end
      if (buffer_load) begin
        buffer <= buffer_next;
      end
    end
  end

endmodule

// File: rtl/sdram_frame_scheduler.sv
// Shares one SDRAM controller between the camera write stream and the display
// read stream with fixed-length bursts and bounded-starvation arbitration.
// Build option: DOUBLE_BUFFER_EN enables ping-pong frame buffers; without it
// both streams use buffer 0 and tearing is permitted.
module sdram_frame_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int unsigned BURST_LENGTH    = DEFAULT_BURST_LENGTH,
  parameter int unsigned FRAME_WORDS     = DEFAULT_FRAME_WORDS,
  parameter int unsigned BUFFER_STRIDE   = DEFAULT_BUFFER_STRIDE,
  parameter int unsigned USED_WIDTH      = DEFAULT_USED_WIDTH,
  parameter int unsigned MAX_CONSECUTIVE = DEFAULT_MAX_CONSECUTIVE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [USED_WIDTH-1:0] write_used,
  output logic                  write_ack,
  input  logic                  write_frame_start,
  input  logic [USED_WIDTH-1:0] read_used,
  output logic                  read_push,
  output logic [1:0]            command,
  output logic [ADDR_WIDTH-1:0] data_address,
  input  logic                  data_read_valid,
  input  logic                  data_write_done,
  output logic                  read_buffer
);

  localparam logic [1:0] ST_IDLE  = CMD_IDLE;
  localparam logic [1:0] ST_WRITE = CMD_WRITE;
  localparam logic [1:0] ST_READ  = CMD_READ;

  localparam int unsigned BEAT_WIDTH   = $clog2(BURST_LENGTH + 1);
  localparam int unsigned CONSEC_WIDTH = $clog2(MAX_CONSECUTIVE + 1);
  localparam logic [USED_WIDTH-1:0] RD_LIMIT = USED_WIDTH'((1 << USED_WIDTH) - BURST_LENGTH - 1);
  localparam logic [USED_WIDTH-1:0] WR_MIN   = USED_WIDTH'(BURST_LENGTH);
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BURST_LENGTH - 1);
  localparam logic [CONSEC_WIDTH-1:0] CONSEC_MAX = CONSEC_WIDTH'(MAX_CONSECUTIVE);

  logic [1:0]              state;
  logic [BEAT_WIDTH-1:0]   beat_cnt;
  logic [CONSEC_WIDTH-1:0] consec_cnt;
  logic                    last_was_write;
  logic                    frame_start_pending;
  logic                    rd_ok, wr_ok, grant_read, grant_write;
  logic                    beat, burst_end, wr_advance, rd_advance, wr_realign;
  logic                    wr_wrap, rd_wrap, write_buffer;
  logic                    wr_buf_load, wr_buf_next, rd_buf_load, rd_buf_next;
  logic [ADDR_WIDTH-1:0]   wr_address, rd_address;

  assign rd_ok = (read_used <= RD_LIMIT);
  assign wr_ok = (write_used >= WR_MIN);

  // Beats only count while the matching burst is active; beats in IDLE are dropped.
  assign write_ack  = data_write_done && (state == ST_WRITE);
  assign read_push  = data_read_valid && (state == ST_READ);
  assign beat       = write_ack || read_push;
  assign burst_end  = beat && (beat_cnt == LAST_BEAT);
  assign wr_advance = burst_end && (state == ST_WRITE);
  assign rd_advance = burst_end && (state == ST_READ);
  assign wr_realign = frame_start_pending && ((state == ST_IDLE) || wr_advance);

  assign command      = state;
  assign data_address = (state == ST_READ)  ? rd_address :
                        (state == ST_WRITE) ? wr_address : '0;

  // Arbitration: reads win ties until they have had MAX_CONSECUTIVE bursts in a row.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    grant_read  = 1'b0;
    grant_write = 1'b0;
    if (state == ST_IDLE) begin
      if (rd_ok && wr_ok) begin
        if (!last_was_write && (consec_cnt >= CONSEC_MAX)) grant_write = 1'b1;
        else                                               grant_read  = 1'b1;
      end else begin
        grant_read  = rd_ok;
        grant_write = wr_ok;
      end
    end
  end

  // Burst sequencing, beat counting and the consecutive-grant counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      beat_cnt       <= '0;
      consec_cnt     <= '0;
      last_was_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (grant_read)       state <= ST_READ;
          else if (grant_write) state <= ST_WRITE;
          if (grant_read || grant_write) begin
            last_was_write <= grant_write;
            if (grant_write != last_was_write)  consec_cnt <= CONSEC_WIDTH'(1);
            else if (consec_cnt < CONSEC_MAX)   consec_cnt <= consec_cnt + 1'b1;
          end
        end
        ST_READ, ST_WRITE: begin
          if (burst_end) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Frame-start request is held until IDLE or the end of the current write
  // burst; a pulse arriving while one is being applied stays pending.
  always_ff @(posedge clk) begin
    if (!reset_n) frame_start_pending <= 1'b0;
    else          frame_start_pending <= write_frame_start || (frame_start_pending && !wr_realign);
  end

`ifdef DOUBLE_BUFFER_EN
  logic last_complete, frame_ready, wr_frame_done;

  // A realignment discards the partial frame, so it never publishes a buffer.
  assign wr_frame_done = wr_wrap && !wr_realign;
  assign wr_buf_load   = wr_wrap || wr_realign;
  assign wr_buf_next   = ~write_buffer;
  // Writer update lands first: a same-cycle reader wrap takes the just-completed buffer.
  assign rd_buf_load   = rd_wrap && (frame_ready || wr_frame_done);
  assign rd_buf_next   = wr_frame_done ? write_buffer : last_complete;

  // Tracks the most recently completed frame and whether the reader has taken it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_complete <= 1'b0;
      frame_ready   <= 1'b0;
    end else begin
      if (wr_frame_done) last_complete <= write_buffer;
      if (rd_buf_load)        frame_ready <= 1'b0;
      else if (wr_frame_done) frame_ready <= 1'b1;
    end
  end
`else
  logic unused_wrap;

  assign wr_buf_load = 1'b0;
  assign wr_buf_next = 1'b0;
  assign rd_buf_load = 1'b0;
  assign rd_buf_next = 1'b0;
  assign unused_wrap = wr_wrap ^ rd_wrap ^ write_buffer;
`endif

  stream_address_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .BURST_LENGTH (BURST_LENGTH),
    .FRAME_WORDS  (FRAME_WORDS),
    .BUFFER_STRIDE(BUFFER_STRIDE)
  ) u_writer (
    .clk        (clk),
    .reset_n    (reset_n),
    .advance    (wr_advance),
    .realign    (wr_realign),
    .buffer_load(wr_buf_load),
    .buffer_next(wr_buf_next),
    .address    (wr_address),
    .buffer     (write_buffer),
    .wrap       (wr_wrap)
  );

  stream_address_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .BURST_LENGTH (BURST_LENGTH),
    .FRAME_WORDS  (FRAME_WORDS),
    .BUFFER_STRIDE(BUFFER_STRIDE)
  ) u_reader (
    .clk        (clk),
    .reset_n    (reset_n),
    .advance    (rd_advance),
    .realign    (1'b0),
    .buffer_load(rd_buf_load),
    .buffer_next(rd_buf_next),
    .address    (rd_address),
    .buffer     (read_buffer),
    .wrap       (rd_wrap)
  );

endmodule

// File: tb/tb_sdram_frame_scheduler.sv
// Directed bench for sdram_frame_scheduler. Uses a short frame (64 words) so
// multi-frame buffer behaviour fits in a few hundred cycles. The controller
// model answers every beat of an active burst on consecutive cycles.
module tb_sdram_frame_scheduler;
  import sdram_sched_pkg::*;

  localparam int AW     = 22;
  localparam int BL     = 8;
  localparam int FW     = 64;
  localparam int STRIDE = 262144;
  localparam int UW     = 5;
  localparam int MAXC   = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [UW-1:0] write_used = '0;
  logic          write_ack;
  logic          write_frame_start = 1'b0;
  logic [UW-1:0] read_used = 5'd31;
  logic          read_push;
  logic [1:0]    command;
  logic [AW-1:0] data_address;
  logic          data_read_valid = 1'b0;
  logic          data_write_done = 1'b0;
  logic          read_buffer;

  logic force_done = 1'b0, force_valid = 1'b0, auto_beats = 1'b1;
  int   n_checks = 0, n_fail = 0;
  int   ack_total = 0, push_total = 0;

  sdram_frame_scheduler #(
    .ADDR_WIDTH(AW), .BURST_LENGTH(BL), .FRAME_WORDS(FW),
    .BUFFER_STRIDE(STRIDE), .USED_WIDTH(UW), .MAX_CONSECUTIVE(MAXC)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .write_used       (write_used),
    .write_ack        (write_ack),
    .write_frame_start(write_frame_start),
    .read_used        (read_used),
    .read_push        (read_push),
    .command          (command),
    .data_address     (data_address),
    .data_read_valid  (data_read_valid),
    .data_write_done  (data_write_done),
    .read_buffer      (read_buffer)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: drive controller beats at negedge, count ack/push before the
  // next posedge, return 1 time unit after the posedge.
  task automatic tick();
    @(negedge clk);
    data_write_done = force_done  | (auto_beats & (command == CMD_WRITE));
    data_read_valid = force_valid | (auto_beats & (command == CMD_READ));
    #2;
    ack_total  += int'(write_ack);
    push_total += int'(read_push);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; write_used = '0; read_used = 5'd31; write_frame_start = 1'b0;
    force_done = 1'b0; force_valid = 1'b0; auto_beats = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  // Wait (bounded) for the next burst, check its command and address, then
  // follow it to completion checking address hold and beat count.
  task automatic run_burst(input string name, input logic [1:0] exp_cmd, input logic [AW-1:0] exp_addr);
    int n, acks0, pushes0, beats, other;
    logic addr_ok;
    n = 0;
    while (command == CMD_IDLE && n < 20) begin tick(); n++; end
    n_checks++;
    if (command !== exp_cmd || data_address !== exp_addr) begin
      n_fail++;
      $display("FAIL %s start: command=%0d address=%0h, expected command=%0d address=%0h",
               name, command, data_address, exp_cmd, exp_addr);
    end
    acks0 = ack_total; pushes0 = push_total; addr_ok = 1'b1; n = 0;
    while (command != CMD_IDLE && n < 20) begin
      if (data_address !== exp_addr) addr_ok = 1'b0;
      tick(); n++;
    end
    n_checks++;
    if (!addr_ok || command !== CMD_IDLE) begin
      n_fail++;
      $display("FAIL %s hold/end: addr_stable=%0b command=%0d, expected addr_stable=1 command=0",
               name, addr_ok, command);
    end
    beats = (exp_cmd == CMD_WRITE) ? ack_total - acks0 : push_total - pushes0;
    other = (exp_cmd == CMD_WRITE) ? push_total - pushes0 : ack_total - acks0;
    n_checks++;
    if (beats != BL || other != 0) begin
      n_fail++;
      $display("FAIL %s beats: counted=%0d other_stream=%0d, expected %0d and 0", name, beats, other, BL);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; force_done = 1'b1; force_valid = 1'b1;
    write_used = 5'd20; read_used = 5'd0;
    repeat (2) tick();
    n_checks++;
    if (command !== 2'd0 || data_address !== '0 || read_buffer !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: command=%0d address=%0h read_buffer=%0b, expected 0 0 0",
               command, data_address, read_buffer);
    end
    n_checks++;
    if (write_ack !== 1'b0 || read_push !== 1'b0) begin
      n_fail++;
      $display("FAIL reset strobes: write_ack=%0b read_push=%0b, expected 0 0", write_ack, read_push);
    end
    // Out of reset with nothing eligible: beats in IDLE produce no ack/push.
    write_used = '0; read_used = 5'd31;
    reset_n = 1'b1;
    ack_total = 0; push_total = 0;
    repeat (3) tick();
    n_checks++;
    if (command !== 2'd0 || ack_total != 0 || push_total != 0) begin
      n_fail++;
      $display("FAIL idle beats ignored: command=%0d acks=%0d pushes=%0d, expected 0 0 0",
               command, ack_total, push_total);
    end
    force_done = 1'b0; force_valid = 1'b0;
  endtask

  task automatic test_single_write();
    apply_reset();
    write_used = 5'd8; read_used = 5'd31;
    run_burst("write0", CMD_WRITE, '0);
    write_used = '0;
    repeat (4) tick();
    n_checks++;
    if (command !== 2'd0) begin
      n_fail++;
      $display("FAIL single write idle: command=%0d, expected 0", command);
    end
    write_used = 5'd8;
    run_burst("write1", CMD_WRITE, 22'd8);
  endtask

  task automatic test_arbitration();
    logic [1:0]    exp_c [10];
    logic [AW-1:0] exp_a [10];
    exp_c = '{CMD_READ, CMD_READ, CMD_READ, CMD_READ, CMD_WRITE,
              CMD_READ, CMD_READ, CMD_READ, CMD_READ, CMD_WRITE};
    exp_a = '{22'd0, 22'd8, 22'd16, 22'd24, 22'd0, 22'd32, 22'd40, 22'd48, 22'd56, 22'd8};
    apply_reset();
    read_used = 5'd0; write_used = 5'd20;
    for (int i = 0; i < 10; i++) run_burst($sformatf("arb%0d", i), exp_c[i], exp_a[i]);
  endtask

  task automatic test_frame_start();
    int n, acks0;
    logic addr_ok;
    apply_reset();
    write_used = 5'd8; read_used = 5'd31;
    n = 0;
    while (command == CMD_IDLE && n < 20) begin tick(); n++; end
    n_checks++;
    if (command !== CMD_WRITE || data_address !== '0) begin
      n_fail++;
      $display("FAIL frame_start burst start: command=%0d address=%0h, expected 1 0", command, data_address);
    end
    acks0 = ack_total;
    repeat (2) tick();
    write_frame_start = 1'b1;
    tick();
    write_frame_start = 1'b0;
    addr_ok = 1'b1; n = 0;
    while (command != CMD_IDLE && n < 20) begin
      if (data_address !== '0) addr_ok = 1'b0;
      tick(); n++;
    end
    n_checks++;
    if (!addr_ok || ack_total - acks0 != BL) begin
      n_fail++;
      $display("FAIL frame_start burst: addr_stable=%0b acks=%0d, expected 1 %0d",
               addr_ok, ack_total - acks0, BL);
    end
`ifdef DOUBLE_BUFFER_EN
    run_burst("after frame_start", CMD_WRITE, AW'(STRIDE));
`else
    run_burst("after frame_start", CMD_WRITE, '0);
`endif
    run_burst("after frame_start next", CMD_WRITE,
`ifdef DOUBLE_BUFFER_EN
              AW'(STRIDE + BL));
`else
              AW'(BL));
`endif
  endtask

  task automatic test_reset_mid_read();
    int n, pushes0;
    apply_reset();
    write_used = '0; read_used = 5'd0;
    n = 0;
    while (command == CMD_IDLE && n < 20) begin tick(); n++; end
    n_checks++;
    if (command !== CMD_READ || data_address !== '0) begin
      n_fail++;
      $display("FAIL mid-read start: command=%0d address=%0h, expected 2 0", command, data_address);
    end
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (command !== 2'd0 || data_address !== '0) begin
      n_fail++;
      $display("FAIL mid-read reset: command=%0d address=%0h, expected 0 0", command, data_address);
    end
    force_valid = 1'b1;
    pushes0 = push_total;
    repeat (2) tick();
    reset_n = 1'b1; read_used = 5'd31;
    repeat (2) tick();
    n_checks++;
    if (push_total - pushes0 != 0 || command !== 2'd0) begin
      n_fail++;
      $display("FAIL mid-read pushes after reset: pushes=%0d command=%0d, expected 0 0",
               push_total - pushes0, command);
    end
    force_valid = 1'b0; read_used = 5'd0;
    run_burst("read after reset", CMD_READ, '0);
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    write_used = 5'd8; read_used = 5'd31;
    for (int k = 0; k < FW / BL; k++) run_burst($sformatf("frame0 wr%0d", k), CMD_WRITE, AW'(k * BL));
`ifdef DOUBLE_BUFFER_EN
    run_burst("frame1 wr0", CMD_WRITE, AW'(STRIDE));
    write_used = '0; read_used = 5'd0;
    for (int k = 0; k < FW / BL; k++) run_burst($sformatf("rd pass0 %0d", k), CMD_READ, AW'(k * BL));
    n_checks++;
    if (read_buffer !== 1'b0) begin
      n_fail++;
      $display("FAIL read_buffer after first wrap: got %0b, expected 0", read_buffer);
    end
    write_used = 5'd8; read_used = 5'd31;
    for (int k = 1; k < FW / BL; k++) run_burst($sformatf("frame1 wr%0d", k), CMD_WRITE, AW'(STRIDE + k * BL));
    write_used = '0; read_used = 5'd0;
    for (int k = 0; k < FW / BL; k++) run_burst($sformatf("rd pass1 %0d", k), CMD_READ, AW'(k * BL));
    n_checks++;
    if (read_buffer !== 1'b1) begin
      n_fail++;
      $display("FAIL read_buffer after second wrap: got %0b, expected 1", read_buffer);
    end
    run_burst("rd buffer1", CMD_READ, AW'(STRIDE));
`else
    run_burst("frame wrap wr", CMD_WRITE, '0);
    write_used = '0; read_used = 5'd0;
    for (int k = 0; k < FW / BL; k++) run_burst($sformatf("rd pass %0d", k), CMD_READ, AW'(k * BL));
    run_burst("rd wrap", CMD_READ, '0);
    n_checks++;
    if (read_buffer !== 1'b0) begin
      n_fail++;
      $display("FAIL read_buffer single buffer: got %0b, expected 0", read_buffer);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_frame_start();
    test_reset_mid_read();
    test_frame_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
